// File: rtl/word_pkg.sv
// Shared letter encoding, validity check and FSM state type for the hangman word matcher.
package word_pkg;

    localparam int CHAR_W = 5;

    localparam logic [CHAR_W-1:0] LETTER_A = CHAR_W'(1);
    localparam logic [CHAR_W-1:0] LETTER_Z = CHAR_W'(26);

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_GUESS,
        ST_SCAN,
        ST_RESULT,
        ST_SOLVED
    } state_t;

    function automatic logic is_letter(input logic [CHAR_W-1:0] c);
        return (c >= LETTER_A) && (c <= LETTER_Z);
    endfunction

endpackage

// File: rtl/word_store.sv
// Secret-word register file: one synchronous write port and one combinational read port.
module word_store
    import word_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int IW      = $clog2(MAX_LEN)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              i_clr,
    input  logic              i_we,
    input  logic [IW-1:0]     i_widx,
    input  logic [CHAR_W-1:0] i_wdata,
    input  logic [IW-1:0]     i_ridx,
    output logic [CHAR_W-1:0] o_rdata
);

    logic [CHAR_W-1:0] r_mem [MAX_LEN];

    // NOTE: the store is small and must read back as zero after reset, so every entry is reset rather than left to RAM inference.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < MAX_LEN; i++) r_mem[i] <= '0;
        end else if (i_clr) begin
            for (int i = 0; i < MAX_LEN; i++) r_mem[i] <= '0;
        end else if (i_we) begin
            r_mem[i_widx] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_ridx];

endmodule

// File: rtl/word_matcher.sv
// Hangman secret-word store and letter matcher; scans one position per cycle per guess.
// Optional guessed-letter tracking is enabled by defining WORD_MATCHER_REPEAT_EN.
module word_matcher
    import word_pkg::*;
#(
    parameter  int MAX_LEN = 8,
    localparam int LW      = $clog2(MAX_LEN + 1)
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic [CHAR_W-1:0]  char,
    input  logic               ld,
    input  logic               done_load,
    input  logic               guess,
    input  logic               newgame,
    output logic [LW-1:0]      wordcount,
    output logic               full,
    output logic               busy,
    output logic               valid,
    output logic               match,
    output logic [LW-1:0]      count,
    output logic [LW-1:0]      remain,
    output logic [MAX_LEN-1:0] reveal_mask,
    output logic               repeat_guess,
    output logic               solved
);

    localparam int IW = $clog2(MAX_LEN);

    state_t             r_state, w_next;
    logic [LW-1:0]      r_wordcount, r_remain, r_count, r_cnt, r_idx;
    logic [MAX_LEN-1:0] r_mask, r_reveal;
    logic               r_match;
    logic [CHAR_W-1:0]  r_letter, w_rdata;
    logic [IW-1:0]      w_ridx;
    logic               w_full, w_char_ok, w_ld_ok, w_done_ok, w_guess_ok;
    logic               w_repeat, w_hit, w_last;
    logic [LW-1:0]      w_cnt_next;
    logic [MAX_LEN-1:0] w_hit_vec;

    assign w_ridx     = r_idx[IW-1:0];
    assign w_full     = (r_wordcount == LW'(MAX_LEN));
    assign w_char_ok  = is_letter(char);
    assign w_done_ok  = (r_state == ST_LOAD) && done_load && (r_wordcount != '0);
    assign w_ld_ok    = (r_state == ST_LOAD) && ld && w_char_ok && !w_full && !w_done_ok;
    assign w_guess_ok = (r_state == ST_GUESS) && guess && w_char_ok;
    assign w_hit      = (r_state == ST_SCAN) && (w_rdata == r_letter) && !r_mask[w_ridx];
    assign w_last     = (r_idx == r_wordcount - LW'(1));
    assign w_cnt_next = r_cnt + LW'(w_hit);
    assign w_hit_vec  = MAX_LEN'(w_hit) << w_ridx;

    word_store #(.MAX_LEN(MAX_LEN), .IW(IW)) u_store (
        .clk    (clk),
        .resetn (resetn),
        .i_clr  (newgame),
        .i_we   (w_ld_ok),
        .i_widx (r_wordcount[IW-1:0]),
        .i_wdata(char),
        .i_ridx (w_ridx),
        .o_rdata(w_rdata)
    );

`ifdef WORD_MATCHER_REPEAT_EN
    logic [25:0]       r_guessed;
    logic              r_repeat;
    logic [CHAR_W-1:0] w_code;

    assign w_code       = char - LETTER_A;
    assign w_repeat     = r_guessed[w_code];
    assign repeat_guess = r_repeat;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_guessed <= '0;
            r_repeat  <= 1'b0;
        end else if (newgame) begin
            r_guessed <= '0;
            r_repeat  <= 1'b0;
        end else if (w_guess_ok) begin
            r_guessed[w_code] <= 1'b1;
            r_repeat          <= w_repeat;
        end else if ((r_state == ST_SCAN) && w_last) begin
            r_repeat <= 1'b0;
        end
    end
`else
    assign w_repeat     = 1'b0;
    assign repeat_guess = 1'b0;
`endif

    // NOTE: registers take non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= ST_LOAD;
        else         r_state <= w_next;
    end

    // NOTE: w_next gets a default before the case so no path leaves it unassigned and infers a latch.
    always_comb begin
        w_next = r_state;
        if (newgame) begin
            w_next = ST_LOAD;
        end else begin
            case (r_state)
                ST_LOAD:   if (w_done_ok) w_next = ST_GUESS;
                ST_GUESS:  if (w_guess_ok) w_next = w_repeat ? ST_RESULT : ST_SCAN;
                ST_SCAN:   if (w_last) w_next = ST_RESULT;
                ST_RESULT: w_next = (r_remain == '0) ? ST_SOLVED : ST_GUESS;
                default:   w_next = r_state;
            endcase
        end
    end

    always_comb begin
        busy   = 1'b0;
        valid  = 1'b0;
        solved = 1'b0;
        case (r_state)
            ST_SCAN:   busy = 1'b1;
            ST_RESULT: begin
                busy  = 1'b1;
                valid = 1'b1;
            end
            ST_SOLVED: solved = 1'b1;
            default:   ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn || newgame) begin
            r_wordcount <= '0;
            r_remain    <= '0;
            r_count     <= '0;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_mask      <= '0;
            r_reveal    <= '0;
            r_match     <= 1'b0;
            r_letter    <= '0;
        end else begin
            if (w_ld_ok)   r_wordcount <= r_wordcount + LW'(1);
            if (w_done_ok) r_remain    <= r_wordcount;
            if (w_guess_ok) begin
                r_letter <= char;
                r_cnt    <= '0;
                r_idx    <= '0;
                if (w_repeat) begin
                    r_count <= '0;
                    r_match <= 1'b0;
                end
            end
            // Results are published only on the last scan step so all outputs change together.
            if (r_state == ST_SCAN) begin
                r_idx  <= r_idx + LW'(1);
                r_cnt  <= w_cnt_next;
                r_mask <= r_mask | w_hit_vec;
                if (w_last) begin
                    r_count  <= w_cnt_next;
                    r_match  <= (w_cnt_next != '0);
                    r_remain <= r_remain - w_cnt_next;
                    r_reveal <= r_mask | w_hit_vec;
                end
            end
        end
    end

    assign wordcount   = r_wordcount;
    assign full        = w_full;
    assign match       = r_match;
    assign count       = r_count;
    assign remain      = r_remain;
    assign reveal_mask = r_reveal;

endmodule

// File: tb/tb_word_matcher.sv
// Scoreboard bench for word_matcher; expected guess results come from a behavioural hangman model.
module tb_word_matcher;

    localparam int MAX_LEN = 8;
    localparam int LW      = $clog2(MAX_LEN + 1);

    logic               clk = 1'b0;
    logic               resetn, ld, done_load, guess, newgame;
    logic [4:0]         char;
    logic [LW-1:0]      wordcount, count, remain;
    logic               full, busy, valid, match, repeat_guess, solved;
    logic [MAX_LEN-1:0] reveal_mask;

    always #5 clk = ~clk;

    word_matcher #(.MAX_LEN(MAX_LEN)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .char        (char),
        .ld          (ld),
        .done_load   (done_load),
        .guess       (guess),
        .newgame     (newgame),
        .wordcount   (wordcount),
        .full        (full),
        .busy        (busy),
        .valid       (valid),
        .match       (match),
        .count       (count),
        .remain      (remain),
        .reveal_mask (reveal_mask),
        .repeat_guess(repeat_guess),
        .solved      (solved)
    );

    typedef struct {
        logic               match;
        logic [LW-1:0]      count;
        logic [LW-1:0]      remain;
        logic [MAX_LEN-1:0] mask;
        logic               rep;
        int                 lat;
    } exp_t;

    exp_t               exp_q[$];
    logic [4:0]         m_word[$];
    logic [MAX_LEN-1:0] m_mask;
    logic [LW-1:0]      m_remain;
    logic [25:0]        m_guessed;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        m_word.delete();
        exp_q.delete();
        m_mask    = '0;
        m_remain  = '0;
        m_guessed = '0;
    endtask

    task automatic push_expected(input logic [4:0] c);
        exp_t e;
        int   n = 0;
        int   li = int'(c) - 1;
        e.rep = 1'b0;
`ifdef WORD_MATCHER_REPEAT_EN
        if (m_guessed[li]) begin
            e.rep = 1'b1; e.match = 1'b0; e.count = '0;
            e.remain = m_remain; e.mask = m_mask; e.lat = 0;
            exp_q.push_back(e);
            return;
        end
`endif
        m_guessed[li] = 1'b1;
        for (int i = 0; i < m_word.size(); i++) begin
            if (m_word[i] == c && !m_mask[i]) begin
                m_mask[i] = 1'b1;
                n++;
            end
        end
        m_remain = m_remain - LW'(n);
        e.match  = (n != 0);
        e.count  = LW'(n);
        e.remain = m_remain;
        e.mask   = m_mask;
        e.lat    = m_word.size();
        exp_q.push_back(e);
    endtask

    task automatic load_letter(input logic [4:0] c);
        char = c; ld = 1'b1;
        tick();
        ld = 1'b0;
        if (c >= 5'd1 && c <= 5'd26 && m_word.size() < MAX_LEN) m_word.push_back(c);
    endtask

    task automatic finish_load();
        done_load = 1'b1;
        tick();
        done_load = 1'b0;
        if (m_word.size() > 0) m_remain = LW'(m_word.size());
    endtask

    task automatic start_game();
        newgame = 1'b1;
        tick();
        newgame = 1'b0;
        model_clear();
    endtask

    task automatic guess_and_check(input string name, input logic [4:0] c, input bit poke_busy);
        exp_t e;
        int   k = 0;
        bit   busy_ok = 1'b1;
        int   extra = 0;
        push_expected(c);
        char = c; guess = 1'b1;
        tick();
        guess = 1'b0;
        if (poke_busy && valid !== 1'b1) begin
            busy_ok &= (busy === 1'b1);
            char = 5'd2; guess = 1'b1;
            tick();
            guess = 1'b0;
            k = 1;
        end
        while (valid !== 1'b1 && k < 40) begin
            busy_ok &= (busy === 1'b1);
            tick();
            k++;
        end
        e = exp_q.pop_front();
        n_tests++;
        if (valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s timeout: valid not seen in %0d cycles, required within %0d", name, k, e.lat);
            return;
        end
        n_tests++;
        if (k != e.lat) begin
            n_fail++;
            $display("FAIL %s latency: got %0d cycles, required %0d", name, k, e.lat);
        end
        n_tests++;
        if (!busy_ok || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s busy: dropped low before/at result, required high", name);
        end
        n_tests++;
        if ({match, count, remain} !== {e.match, e.count, e.remain}) begin
            n_fail++;
            $display("FAIL %s result: match/count/remain got %b/%0d/%0d, required %b/%0d/%0d",
                     name, match, count, remain, e.match, e.count, e.remain);
        end
        n_tests++;
        if ({reveal_mask, repeat_guess} !== {e.mask, e.rep}) begin
            n_fail++;
            $display("FAIL %s mask/repeat: got %b/%b, required %b/%b", name, reveal_mask, repeat_guess, e.mask, e.rep);
        end
        tick();
        n_tests++;
        if (valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s strobe: valid got %b a cycle later, required 0", name, valid);
        end
        if (poke_busy) begin
            for (int i = 0; i < 8; i++) begin
                if (valid === 1'b1) extra++;
                tick();
            end
            n_tests++;
            if (extra != 0 || remain !== e.remain) begin
                n_fail++;
                $display("FAIL %s dropped-guess: %0d extra results, remain %0d, required 0 and %0d",
                         name, extra, remain, e.remain);
            end
        end
    endtask

    task automatic check_cleared(input string name);
        n_tests++;
        if ({wordcount, full, busy, valid, match, count, remain, reveal_mask, repeat_guess, solved} !== '0) begin
            n_fail++;
            $display("FAIL %s clear: wc=%0d full=%b busy=%b valid=%b match=%b cnt=%0d rem=%0d mask=%b rep=%b sol=%b, required all 0",
                     name, wordcount, full, busy, valid, match, count, remain, reveal_mask, repeat_guess, solved);
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        tick(); tick();
        check_cleared("reset");
        resetn = 1'b1;
        model_clear();
    endtask

    task automatic test_load();
        finish_load();
        load_letter(5'd2);
        load_letter(5'd15);
        load_letter(5'd0);
        load_letter(5'd15);
        load_letter(5'd27);
        load_letter(5'd11);
        n_tests++;
        if (wordcount !== LW'(m_word.size()) || full !== 1'b0) begin
            n_fail++;
            $display("FAIL load_count: wordcount/full got %0d/%b, required %0d/0", wordcount, full, m_word.size());
        end
        finish_load();
        n_tests++;
        if (remain !== LW'(4) || wordcount !== LW'(4) || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL load_done: remain/wordcount/busy got %0d/%0d/%b, required 4/4/0", remain, wordcount, busy);
        end
    endtask

    task automatic test_guess();
        guess_and_check("guess_O", 5'd15, 1'b0);
        guess_and_check("guess_Z", 5'd26, 1'b0);
        guess_and_check("guess_B", 5'd2,  1'b0);
        guess_and_check("guess_K", 5'd11, 1'b0);
        n_tests++;
        if (solved !== 1'b1 || remain !== '0 || reveal_mask !== MAX_LEN'(8'h0F)) begin
            n_fail++;
            $display("FAIL solved: solved/remain/mask got %b/%0d/%b, required 1/0/00001111", solved, remain, reveal_mask);
        end
        char = 5'd1; guess = 1'b1;
        tick();
        guess = 1'b0;
        tick();
        n_tests++;
        if (solved !== 1'b1 || busy !== 1'b0 || valid !== 1'b0) begin
            n_fail++;
            $display("FAIL solved_hold: solved/busy/valid got %b/%b/%b, required 1/0/0", solved, busy, valid);
        end
    endtask

    task automatic test_back_to_back();
        start_game();
        load_letter(5'd2); load_letter(5'd15); load_letter(5'd15); load_letter(5'd11);
        finish_load();
        guess_and_check("busy_drop", 5'd15, 1'b1);
    endtask

    task automatic test_repeat();
        start_game();
        load_letter(5'd2); load_letter(5'd15); load_letter(5'd15); load_letter(5'd11);
        finish_load();
        guess_and_check("repeat_first", 5'd15, 1'b0);
        guess_and_check("repeat_second", 5'd15, 1'b0);
        guess_and_check("repeat_after", 5'd26, 1'b0);
    endtask

    task automatic test_full();
        start_game();
        for (int i = 1; i <= 9; i++) load_letter(5'(i));
        n_tests++;
        if (wordcount !== LW'(MAX_LEN) || full !== 1'b1) begin
            n_fail++;
            $display("FAIL full: wordcount/full got %0d/%b, required %0d/1", wordcount, full, MAX_LEN);
        end
    endtask

    task automatic test_abort();
        int pulses = 0;
        start_game();
        load_letter(5'd1); load_letter(5'd2); load_letter(5'd3);
        finish_load();
        char = 5'd1; guess = 1'b1;
        tick();
        guess = 1'b0;
        tick();
        resetn = 1'b0;
        #1;
        check_cleared("reset_mid_scan");
        for (int i = 0; i < 5; i++) begin
            tick();
            if (valid === 1'b1) pulses++;
        end
        resetn = 1'b1;
        n_tests++;
        if (pulses != 0) begin
            n_fail++;
            $display("FAIL reset_no_valid: %0d valid pulses, required 0", pulses);
        end
        model_clear();
        load_letter(5'd3); load_letter(5'd1); load_letter(5'd20);
        finish_load();
        start_game();
        check_cleared("newgame_in_guess");
        char = 5'd1; guess = 1'b1;
        tick();
        guess = 1'b0;
        load_letter(5'd1);
        n_tests++;
        if (wordcount !== LW'(1) || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL newgame_load: wordcount/busy got %0d/%b, required 1/0", wordcount, busy);
        end
    endtask

    initial begin
        ld = 1'b0; done_load = 1'b0; guess = 1'b0; newgame = 1'b0; char = '0;
        test_reset();
        test_load();
        test_guess();
        test_back_to_back();
        test_repeat();
        test_full();
        test_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
